pool_max: RTL and testbench
===========================

POOL_MAX -- requirements
Module: pool_max

Interface
REQ-001 SHALL have parameter NUM_WIDTH, default 16, width of a signed two's-complement activation.
REQ-002 SHALL have parameter DIM_WIDTH, default 8, width of the row/column size and counter fields.
REQ-003 SHALL have parameter MAX_COLS, default 256, maximum feature-map width; line buffer holds MAX_COLS/2 entries.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 bypass  input  1  1 = pass every accepted pixel through unpooled; sampled with cfg_start.
REQ-007 cfg_start  input  1  single-cycle frame start pulse; honoured only in IDLE.
REQ-008 cfg_cols  input  DIM_WIDTH  frame width in pixels; sampled with cfg_start.
REQ-009 cfg_rows  input  DIM_WIDTH  frame height in pixels; sampled with cfg_start.
REQ-010 up_valid  input  1  upstream pixel valid.
REQ-011 up_ready  output  1  block accepts pixel this cycle.
REQ-012 up_data  input  NUM_WIDTH  pixel, row-major order.
REQ-013 dn_valid  output  1  output register holds a result.
REQ-014 dn_ready  input  1  downstream accepts result.
REQ-015 dn_data  output  NUM_WIDTH  pooled (or bypassed) value.
REQ-016 dn_last  output  1  marks final result of the frame.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 Pixel accepted when up_valid && up_ready; dn result transferred when dn_valid && dn_ready.
REQ-019 up_ready SHALL be 0 in IDLE, else (!dn_valid || dn_ready).
REQ-020 FSM states IDLE, EVEN_ROW, ODD_ROW; IDLE->EVEN_ROW on cfg_start with valid cfg; EVEN_ROW->ODD_ROW after last column of even row; ODD_ROW->EVEN_ROW after last column of odd row; ->IDLE after final pixel of frame accepted.
REQ-021 cfg_cols[0] and cfg_rows[0] SHALL be ignored (treated as 0); cfg_start with effective cols <2, rows <2, or cols >MAX_COLS SHALL be ignored, state stays IDLE.
REQ-022 cfg_start outside IDLE SHALL be ignored.
REQ-023 Pooling: 2x2 window, stride 2, signed max; pixel (r,c) belongs to window (r/2, c/2).
REQ-024 EVEN_ROW: even-column pixel held in pair register; odd-column pixel: max(pair, pixel) written to line buffer entry c/2; no output produced.
REQ-025 ODD_ROW: odd-column pixel: result = max(pair, pixel, linebuf[c/2]) loaded into output register.
REQ-026 Latency: dn_valid asserted the cycle after the accepting edge of the window's fourth pixel.
REQ-027 Ties SHALL return the equal value; comparisons signed over full NUM_WIDTH, no saturation or width change.
REQ-028 Bypass frame: every accepted pixel loaded into output register unchanged, latency 1; frame ends after cols*rows pixels.
REQ-029 dn_last SHALL be 1 with the frame's final result (pooled: window (rows/2-1, cols/2-1); bypass: last pixel), else 0.
REQ-030 dn_data, dn_last SHALL hold stable while dn_valid && !dn_ready.
REQ-031 Column counter wraps to 0 after cols-1; row counter increments on wrap; no counter exceeds programmed size.
REQ-032 Output register load and drain in the same cycle SHALL be supported (full throughput, one result per window).
REQ-033 Returning to IDLE SHALL not drop a pending output; busy deasserts after final pixel acceptance, dn_valid may remain high.

Reset
REQ-034 rst_n low SHALL immediately force state IDLE, counters 0, dn_valid 0, dn_last 0, dn_data 0, up_ready 0, busy 0.
REQ-035 Line buffer and pair register contents need not reset; no output SHALL depend on stale contents.
REQ-036 Reset mid-frame SHALL abandon the frame; the next cfg_start begins cleanly.

Verification
REQ-037 4x2 frame, rows {1,5,-3,2},{4,0,7,-8}, dn_ready=1 -> outputs 5, 7; dn_last on 7; busy low after 8th pixel.
REQ-038 Same frame with bypass=1 -> 8 outputs equal to inputs in order, dn_last on -8.
REQ-039 4x4 frame, dn_ready held 0 after first result -> up_ready 0 on next window-completing pixel, dn_data stable; release -> all 4 results, none lost.
REQ-040 cfg_cols=1 or cfg_rows=3 (effective 2) and cfg_cols=MAX_COLS+2 -> first ignored (busy stays 0), second runs 2 rows, third ignored.
REQ-041 rst_n asserted after 5 pixels of 4x4 frame, then new 2x2 frame {-1,-2},{-3,-4} -> single output -1 with dn_last.

Source files
------------

// File: rtl/pool_max.sv
// pool_max: streaming 2x2 stride-2 signed max pooling with an optional bypass mode.
// Even rows fold column pairs into a half-width line buffer; odd rows complete each window.
module pool_max #(
    parameter int NUM_WIDTH = 16,
    parameter int DIM_WIDTH = 8,
    parameter int MAX_COLS  = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bypass,
    input  logic                 cfg_start,
    input  logic [DIM_WIDTH-1:0] cfg_cols,
    input  logic [DIM_WIDTH-1:0] cfg_rows,
    input  logic                 up_valid,
    output logic                 up_ready,
    input  logic [NUM_WIDTH-1:0] up_data,
    output logic                 dn_valid,
    input  logic                 dn_ready,
    output logic [NUM_WIDTH-1:0] dn_data,
    output logic                 dn_last,
    output logic                 busy
);
    localparam int LB_DEPTH = MAX_COLS / 2;
    localparam int LB_AW    = LB_DEPTH > 1 ? $clog2(LB_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, EVEN_ROW, ODD_ROW} state_t;

    state_t               state_q, state_d;
    logic [DIM_WIDTH-1:0] col_q, col_d, row_q, row_d, cols_q, cols_d, rows_q, rows_d;
    logic [DIM_WIDTH-1:0] eff_cols, eff_rows;
    logic                 bypass_q, bypass_d, dn_valid_q, dn_valid_d, dn_last_q, dn_last_d;
    logic [NUM_WIDTH-1:0] pair_q, pair_d, dn_data_q, dn_data_d, m1, m2, lb_rd;
    logic [NUM_WIDTH-1:0] lb_q [LB_DEPTH];
    logic [LB_AW-1:0]     lb_idx;
    logic                 acc, cfg_ok, last_col, last_row, lb_we, load;

    assign lb_idx   = col_q[LB_AW:1];
    assign up_ready = state_q != IDLE && (!dn_valid_q || dn_ready);
    assign busy     = state_q != IDLE;
    assign dn_valid = dn_valid_q;
    assign dn_data  = dn_data_q;
    assign dn_last  = dn_last_q;

    always_comb begin
        eff_cols   = cfg_cols & ~DIM_WIDTH'(1);
        eff_rows   = cfg_rows & ~DIM_WIDTH'(1);
        cfg_ok     = eff_cols >= DIM_WIDTH'(2) && eff_rows >= DIM_WIDTH'(2) && int'(eff_cols) <= MAX_COLS;
        acc        = up_valid && up_ready;
        last_col   = col_q == cols_q - DIM_WIDTH'(1);
        last_row   = row_q == rows_q - DIM_WIDTH'(1);
        lb_rd      = lb_q[lb_idx];
        m1         = $signed(up_data) > $signed(pair_q) ? up_data : pair_q;
        m2         = $signed(lb_rd) > $signed(m1) ? lb_rd : m1;
        lb_we      = acc && state_q == EVEN_ROW && col_q[0] && !bypass_q;
        load       = acc && (bypass_q || (state_q == ODD_ROW && col_q[0]));
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        cols_d     = cols_q;
        rows_d     = rows_q;
        bypass_d   = bypass_q;
        pair_d     = acc && !col_q[0] ? up_data : pair_q;
        if (state_q == IDLE) begin
            if (cfg_start && cfg_ok) begin
                state_d  = EVEN_ROW;
                col_d    = '0;
                row_d    = '0;
                cols_d   = eff_cols;
                rows_d   = eff_rows;
                bypass_d = bypass;
            end
        end else if (acc) begin
            col_d   = last_col ? '0 : col_q + DIM_WIDTH'(1);
            row_d   = !last_col ? row_q : last_row ? '0 : row_q + DIM_WIDTH'(1);
            state_d = !last_col ? state_q : last_row ? IDLE : state_q == EVEN_ROW ? ODD_ROW : EVEN_ROW;
        end
        dn_valid_d = load || (dn_valid_q && !dn_ready);
        dn_data_d  = load ? (bypass_q ? up_data : m2) : dn_data_q;
        dn_last_d  = load ? last_col && last_row : dn_last_q && !(dn_valid_q && dn_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            col_q      <= '0;
            row_q      <= '0;
            cols_q     <= '0;
            rows_q     <= '0;
            bypass_q   <= 1'b0;
            pair_q     <= '0;
            dn_valid_q <= 1'b0;
            dn_data_q  <= '0;
            dn_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            cols_q     <= cols_d;
            rows_q     <= rows_d;
            bypass_q   <= bypass_d;
            pair_q     <= pair_d;
            dn_valid_q <= dn_valid_d;
            dn_data_q  <= dn_data_d;
            dn_last_q  <= dn_last_d;
        end
    end

    // Contents are always rewritten on an even row before the odd row reads them.
    always_ff @(posedge clk) begin
        if (lb_we) lb_q[lb_idx] <= m1;
    end
endmodule

// File: tb/tb_pool_max.sv
// tb_pool_max: directed frames against a window-max reference model, checked on every transfer.
module tb_pool_max;
    localparam int NW = 16;
    localparam int DW = 8;
    localparam int MC = 8;

    typedef logic signed [NW-1:0] sn_t;

    logic clk = 0, rst_n = 0, bypass = 0, cfg_start = 0, up_valid = 0, dn_ready = 1;
    logic [DW-1:0] cfg_cols = '0, cfg_rows = '0;
    logic [NW-1:0] up_data = '0;
    logic up_ready, dn_valid, dn_last, busy;
    logic [NW-1:0] dn_data;

    int  tests = 0, fails = 0;
    int  pix[$];
    sn_t exp_d[$];
    bit  exp_l[$];
    sn_t got_q[$];

    always #5 clk = ~clk;

    pool_max #(.NUM_WIDTH(NW), .DIM_WIDTH(DW), .MAX_COLS(MC)) dut (
        .clk(clk), .rst_n(rst_n), .bypass(bypass), .cfg_start(cfg_start),
        .cfg_cols(cfg_cols), .cfg_rows(cfg_rows), .up_valid(up_valid), .up_ready(up_ready),
        .up_data(up_data), .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data),
        .dn_last(dn_last), .busy(busy)
    );

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    // Reference: window maxima in window raster order, or raw pixels in bypass.
    task automatic build_exp(input int cols, input int rows, input bit byp);
        if (byp) begin
            for (int i = 0; i < cols * rows; i++) begin
                exp_d.push_back(sn_t'(pix[i]));
                exp_l.push_back(i == cols * rows - 1);
            end
        end else begin
            for (int wr = 0; wr < rows / 2; wr++)
                for (int wc = 0; wc < cols / 2; wc++) begin
                    int m;
                    m = pix[2 * wr * cols + 2 * wc];
                    for (int dr = 0; dr < 2; dr++)
                        for (int dc = 0; dc < 2; dc++)
                            if (pix[(2 * wr + dr) * cols + 2 * wc + dc] > m) m = pix[(2 * wr + dr) * cols + 2 * wc + dc];
                    exp_d.push_back(sn_t'(m));
                    exp_l.push_back(wr == rows / 2 - 1 && wc == cols / 2 - 1);
                end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && dn_valid && dn_ready) begin
            got_q.push_back(sn_t'(dn_data));
            if (exp_d.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                check("out_data", int'($signed(dn_data)), int'(exp_d[0]));
                check("out_last", int'(dn_last), int'(exp_l[0]));
                void'(exp_d.pop_front());
                void'(exp_l.pop_front());
            end
        end
    end

    task automatic start(input int c, input int r, input bit b);
        cfg_cols  = DW'(c);
        cfg_rows  = DW'(r);
        bypass    = b;
        cfg_start = 1;
        @(posedge clk); #1;
        cfg_start = 0;
    endtask

    task automatic send(input int v, output int waits);
        bit done;
        done     = 0;
        waits    = 0;
        up_valid = 1;
        up_data  = NW'(v);
        while (!done) begin
            @(negedge clk);
            done = up_ready;
            @(posedge clk); #1;
            if (!done) begin
                waits++;
                if (waits > 100) begin
                    check("send_timeout", waits, 0);
                    done = 1;
                end
            end
        end
        up_valid = 0;
    endtask

    task automatic send_n(input int n);
        int w;
        for (int i = 0; i < n; i++) send(pix[i], w);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && exp_d.size() > 0; n++) @(posedge clk);
        #1;
        check("drain_empty", exp_d.size(), 0);
    endtask

    initial begin
        int w, stalls;
        #3;
        check("rst_dn_valid", int'(dn_valid), 0);
        check("rst_dn_last", int'(dn_last), 0);
        check("rst_dn_data", int'(dn_data), 0);
        check("rst_up_ready", int'(up_ready), 0);
        check("rst_busy", int'(busy), 0);
        #10 rst_n = 1;
        @(posedge clk); #1;

        pix = '{1, 5, -3, 2, 4, 0, 7, -8};
        build_exp(4, 2, 0);
        check("model_w0", int'(exp_d[0]), 5);
        check("model_w1", int'(exp_d[1]), 7);
        check("model_last", int'(exp_l[1]), 1);
        got_q.delete();
        start(4, 2, 0);
        check("busy_started", int'(busy), 1);
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            send(pix[i], w);
            stalls += w;
            if (i == 5) begin
                check("latency_valid", int'(dn_valid), 1);
                check("latency_data", int'($signed(dn_data)), 5);
            end
        end
        check("busy_done", int'(busy), 0);
        check("no_stalls", stalls, 0);
        drain();
        check("pool_count", got_q.size(), 2);
        check("pool_r0", int'(got_q[0]), 5);
        check("pool_r1", int'(got_q[1]), 7);

        got_q.delete();
        build_exp(4, 2, 1);
        start(4, 2, 1);
        send_n(8);
        drain();
        check("byp_count", got_q.size(), 8);
        check("byp_r2", int'(got_q[2]), -3);
        check("byp_r7", int'(got_q[7]), -8);

        pix = '{3, -1, 8, 2, 0, 7, -5, 4, -9, -9, -2, -6, -9, -3, -6, -2};
        got_q.delete();
        build_exp(4, 4, 0);
        check("model_tie", int'(exp_d[3]), -2);
        start(4, 4, 0);
        fork
            send_n(16);
            begin
                for (int k = 0; k < 200; k++) begin
                    @(posedge clk); #1;
                    if (dn_valid) break;
                end
                dn_ready = 0;
                check("stall_first", int'($signed(dn_data)), 7);
                repeat (8) begin
                    @(negedge clk);
                    check("stall_ready_low", int'(up_ready), 0);
                    check("stall_valid", int'(dn_valid), 1);
                    check("stall_hold", int'($signed(dn_data)), 7);
                end
                @(posedge clk); #1;
                dn_ready = 1;
            end
        join
        drain();
        check("stall_count", got_q.size(), 4);
        check("stall_r1", int'(got_q[1]), 8);
        check("stall_r2", int'(got_q[2]), -3);
        check("stall_r3", int'(got_q[3]), -2);

        start(1, 2, 0);
        check("cfg_cols1_ignored", int'(busy), 0);
        pix = '{3, -7, 9, 2};
        got_q.delete();
        build_exp(2, 2, 0);
        start(2, 3, 0);
        check("cfg_rows3_runs", int'(busy), 1);
        send_n(4);
        check("cfg_rows3_two_rows", int'(busy), 0);
        drain();
        check("cfg_rows3_out", int'(got_q[0]), 9);
        start(MC + 2, 2, 0);
        check("cfg_too_wide_ignored", int'(busy), 0);

        pix.delete();
        for (int i = 0; i < 16; i++) pix.push_back(i - 8);
        got_q.delete();
        build_exp(MC, 2, 0);
        start(MC, 2, 0);
        check("cfg_max_cols_runs", int'(busy), 1);
        send_n(16);
        drain();
        check("max_cols_count", got_q.size(), 4);
        check("max_cols_r0", int'(got_q[0]), 1);
        check("max_cols_r3", int'(got_q[3]), 7);

        pix = '{50, 60, 70, 80, 90, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10};
        build_exp(4, 4, 0);
        start(4, 4, 0);
        send_n(5);
        rst_n = 0;
        #1;
        check("midrst_busy", int'(busy), 0);
        check("midrst_up_ready", int'(up_ready), 0);
        check("midrst_dn_valid", int'(dn_valid), 0);
        exp_d.delete();
        exp_l.delete();
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        pix = '{-1, -2, -3, -4};
        got_q.delete();
        build_exp(2, 2, 0);
        check("model_2x2_last", int'(exp_l[0]), 1);
        start(2, 2, 0);
        send_n(4);
        drain();
        check("after_rst_count", got_q.size(), 1);
        check("after_rst_out", int'(got_q[0]), -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
